// File: rtl/spi_m_tx_arb.sv
// Two-requester round-robin arbiter in front of a single SPI master transmitter.
// Optional sticky-ownership lock, compiled in when SPI_ARB_LOCK_EN is defined.
module spi_m_tx_arb #(
  parameter int DATA_W   = 8,
  parameter int ACK_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // Requester handshake: valid and data are held until the requester sees ready.
  // Ready is a one-cycle combinational accept, raised only in IDLE while the
  // transmitter is idle, for at most one requester; the word is taken on the
  // rising edge where valid and ready are both high.
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
`ifdef SPI_ARB_LOCK_EN
  input  logic              i_req0_lock,
  input  logic              i_req1_lock,
`endif
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_data_valid,
  input  logic              i_spi_busy,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic              o_err,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam int               CNT_W    = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic              arm_q, arm_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [1:0]        grant_q, grant_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio1_q, prio1_d;
  logic              accept;
  logic              win1;
  logic              hold_ptr;
`ifdef SPI_ARB_LOCK_EN
  logic              lock_act_q, lock_act_d;
  logic              lock_id_q, lock_id_d;
`endif

  // arm_q holds off the first accept until one full cycle after reset release.
  always_comb begin
    win1     = i_req1_valid & (~i_req0_valid | prio1_q);
    hold_ptr = 1'b0;
`ifdef SPI_ARB_LOCK_EN
    if (lock_act_q && (lock_id_q ? i_req1_valid : i_req0_valid)) begin
      win1     = lock_id_q;
      hold_ptr = 1'b1;
    end
`endif
    accept = (state_q == S_IDLE) && arm_q && (i_req0_valid || i_req1_valid) && !i_spi_busy;
  end

  assign o_req0_ready = accept & ~win1;
  assign o_req1_ready = accept & win1;

  always_comb begin
    state_d    = state_q;
    arm_d      = 1'b1;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    grant_d    = grant_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    prio1_d    = prio1_q;
`ifdef SPI_ARB_LOCK_EN
    lock_act_d = lock_act_q;
    lock_id_d  = lock_id_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_LAUNCH;
          tx_data_d  = win1 ? i_req1_data : i_req0_data;
          tx_valid_d = 1'b1;
          grant_d    = win1 ? 2'b10 : 2'b01;
          if (!hold_ptr) prio1_d = ~win1;
`ifdef SPI_ARB_LOCK_EN
          lock_act_d = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_ACK;
        cnt_d   = '0;
      end
      S_WAIT_ACK: begin
        if (i_spi_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          grant_d = 2'b00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (!i_spi_busy) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
`ifdef SPI_ARB_LOCK_EN
          // Ownership is retained only if the owner still asks for it at release.
          lock_id_d  = grant_q[1];
          lock_act_d = grant_q[1] ? i_req1_lock : i_req0_lock;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      prio1_q    <= 1'b0;
`ifdef SPI_ARB_LOCK_EN
      lock_act_q <= 1'b0;
      lock_id_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      prio1_q    <= prio1_d;
`ifdef SPI_ARB_LOCK_EN
      lock_act_q <= lock_act_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_grant         = grant_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_err           = err_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_spi_m_tx_arb.sv
// Self-checking bench for spi_m_tx_arb: directed scenarios plus a randomized
// two-requester run scored against a transaction-level round-robin model.
module tb_spi_m_tx_arb;
  localparam int ACK_WAIT = 4;
  localparam int LOG_N    = 512;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_req0_data = 8'h00;
  logic       i_req0_valid = 1'b0;
  logic       o_req0_ready;
  logic [7:0] i_req1_data = 8'h00;
  logic       i_req1_valid = 1'b0;
  logic       o_req1_ready;
`ifdef SPI_ARB_LOCK_EN
  logic       i_req0_lock = 1'b0;
  logic       i_req1_lock = 1'b0;
`endif
  logic [7:0] o_tx_data;
  logic       o_tx_data_valid;
  logic       i_spi_busy;
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_err;
  logic [1:0] o_dbg_state;

  spi_m_tx_arb #(.DATA_W(8), .ACK_WAIT(ACK_WAIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_data(i_req0_data), .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req1_data(i_req1_data), .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
`ifdef SPI_ARB_LOCK_EN
    .i_req0_lock(i_req0_lock), .i_req1_lock(i_req1_lock),
`endif
    .o_tx_data(o_tx_data), .o_tx_data_valid(o_tx_data_valid), .i_spi_busy(i_spi_busy),
    .o_grant(o_grant), .o_busy(o_busy), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- requester stimulus (word lists + feeders) ----------------
  logic [7:0] words0[LOG_N];
  logic [7:0] words1[LOG_N];
  int n0 = 0, n1 = 0;      // written by tasks
  int idx0 = 0, idx1 = 0;  // written by feeder
  bit acc0 = 0, acc1 = 0;  // written by monitor
  bit lock1_mode = 0;

  task automatic push0(input logic [7:0] d); words0[n0] = d; n0++; endtask
  task automatic push1(input logic [7:0] d); words1[n1] = d; n1++; endtask

  always @(posedge i_clk) begin
    #1;
    if (acc0) idx0++;
    if (acc1) idx1++;
    i_req0_valid = (idx0 < n0);
    i_req0_data  = (idx0 < n0) ? words0[idx0] : 8'h00;
    i_req1_valid = (idx1 < n1);
    i_req1_data  = (idx1 < n1) ? words1[idx1] : 8'h00;
`ifdef SPI_ARB_LOCK_EN
    i_req1_lock  = lock1_mode && (idx1 < n1);
`endif
  end

  // ---------------- transmitter model ----------------
  bit model_busy = 0, ack_arm = 0;
  bit force_busy = 0, tx_ack_en = 1;
  int hold_left = 0, tx_hold = 4;
  assign i_spi_busy = model_busy | force_busy;

  always @(posedge i_clk) begin
    #1;
    if (!i_rst_n) begin
      model_busy = 0; hold_left = 0; ack_arm = 0;
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) model_busy = 0;
      end
      if (ack_arm) begin ack_arm = 0; model_busy = 1; hold_left = tx_hold; end
      if (o_tx_data_valid && tx_ack_en) ack_arm = 1;
    end
  end

  // ---------------- monitor / logs ----------------
  int rdy0_cnt = 0, rdy1_cnt = 0, viol_cnt = 0;
  int ev_n = 0, st_n = 0;
  bit ev_v0[LOG_N], ev_v1[LOG_N], ev_r1[LOG_N];
  logic [7:0] st_data[LOG_N];
  logic [1:0] st_grant[LOG_N];
  bit in_xfer = 0, prev_strobe = 0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge i_clk) begin
    acc0 = o_req0_ready;
    acc1 = o_req1_ready;
    if (!i_rst_n) begin
      in_xfer = 0; prev_strobe = 0;
    end else begin
      if (o_req0_ready) rdy0_cnt++;
      if (o_req1_ready) rdy1_cnt++;
      if ((o_req0_ready || o_req1_ready) && ev_n < LOG_N) begin
        ev_v0[ev_n] = i_req0_valid; ev_v1[ev_n] = i_req1_valid; ev_r1[ev_n] = o_req1_ready;
        ev_n++;
      end
      if (o_req0_ready && o_req1_ready) viol_cnt++;
      if ((o_req0_ready || o_req1_ready) && o_busy) viol_cnt++;
      if (o_busy ? !(o_grant == 2'b01 || o_grant == 2'b10) : (o_grant != 2'b00)) viol_cnt++;
      if (o_tx_data_valid) begin
        if (prev_strobe) viol_cnt++;
        if (st_n < LOG_N) begin
          st_data[st_n] = o_tx_data; st_grant[st_n] = o_grant; st_n++;
        end
        hold_data = o_tx_data; in_xfer = 1;
      end else if (in_xfer && o_busy && o_tx_data !== hold_data) begin
        viol_cnt++;
      end
      if (!o_busy) in_xfer = 0;
      prev_strobe = o_tx_data_valid;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (o_tx_data_valid) begin ok = 1; break; end
    end
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    int quiet;
    quiet = 0; ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (idx0 == n0 && idx1 == n1 && !o_busy && !i_spi_busy) quiet++; else quiet = 0;
      if (quiet >= 3) begin ok = 1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    push0(8'h96);
    repeat (3) @(negedge i_clk);
    total_cnt++; if (o_req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", o_req0_ready); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", o_grant); else pass_cnt++;
    total_cnt++; if (o_tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", o_tx_data); else pass_cnt++;
    total_cnt++; if (o_tx_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_tx_data_valid); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0) $display("FAIL rst_err: got %b want 0", o_err); else pass_cnt++;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_first_edge_busy: got %b want 0", o_busy); else pass_cnt++;
    @(negedge i_clk);
    total_cnt++; if (o_tx_data_valid !== 1'b1 || o_tx_data !== 8'h96)
      $display("FAIL rst_second_edge_launch: got valid=%b data=%h want 1/96", o_tx_data_valid, o_tx_data);
    else pass_cnt++;
    begin
      bit ok;
      wait_drain(200, ok);
      total_cnt++; if (!ok) $display("FAIL rst_drain: timeout got 0 want 1"); else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int b_r0, b_st;
    bit ok;
    tx_hold = 40;
    b_r0 = rdy0_cnt; b_st = st_n;
    push0(8'hAD);
    wait_strobe(50, ok);
    total_cnt++; if (!ok) $display("FAIL single_strobe: timeout got 0 want 1"); else pass_cnt++;
    total_cnt++; if (o_tx_data !== 8'hAD) $display("FAIL single_data: got %h want ad", o_tx_data); else pass_cnt++;
    total_cnt++; if (o_grant !== 2'b01) $display("FAIL single_grant_launch: got %b want 01", o_grant); else pass_cnt++;
    repeat (10) @(negedge i_clk);
    total_cnt++; if (o_grant !== 2'b01 || o_busy !== 1'b1)
      $display("FAIL single_grant_hold: got grant=%b busy=%b want 01/1", o_grant, o_busy);
    else pass_cnt++;
    wait_drain(200, ok);
    total_cnt++; if (!ok) $display("FAIL single_drain: timeout got 0 want 1"); else pass_cnt++;
    total_cnt++; if (o_grant !== 2'b00) $display("FAIL single_grant_idle: got %b want 00", o_grant); else pass_cnt++;
    total_cnt++; if (rdy0_cnt - b_r0 !== 1) $display("FAIL single_ready_count: got %0d want 1", rdy0_cnt - b_r0); else pass_cnt++;
    total_cnt++; if (st_n - b_st !== 1) $display("FAIL single_strobe_count: got %0d want 1", st_n - b_st); else pass_cnt++;
  endtask

  task automatic test_tie();
    int b_st;
    bit ok;
    logic [7:0] exp_d[4];
    logic [1:0] exp_g[4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    tx_hold = 3;
    b_st = st_n;
    push0(8'h11); push0(8'h11); push1(8'h22); push1(8'h22);
    wait_drain(400, ok);
    total_cnt++; if (!ok || st_n - b_st !== 4) $display("FAIL tie_count: got %0d want 4", st_n - b_st); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (st_data[b_st+i] !== exp_d[i] || st_grant[b_st+i] !== exp_g[i])
        $display("FAIL tie_order[%0d]: got %h/%b want %h/%b", i, st_data[b_st+i], st_grant[b_st+i], exp_d[i], exp_g[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_no_ack();
    bit ok;
    tx_ack_en = 0;
    push0(8'h5A);
    wait_strobe(50, ok);
    total_cnt++; if (!ok) $display("FAIL noack_strobe: timeout got 0 want 1"); else pass_cnt++;
    for (int k = 1; k <= ACK_WAIT + 1; k++) begin
      @(negedge i_clk);
      if (k == ACK_WAIT) begin
        total_cnt++; if (o_err !== 1'b0 || o_busy !== 1'b1)
          $display("FAIL noack_early: got err=%b busy=%b want 0/1", o_err, o_busy);
        else pass_cnt++;
      end
      if (k == ACK_WAIT + 1) begin
        total_cnt++; if (o_err !== 1'b1 || o_busy !== 1'b0 || o_grant !== 2'b00)
          $display("FAIL noack_expire: got err=%b busy=%b grant=%b want 1/0/00", o_err, o_busy, o_grant);
        else pass_cnt++;
      end
    end
    tx_ack_en = 1;
    tx_hold = 5;
    push0(8'h3C);
    wait_strobe(50, ok);
    total_cnt++; if (!ok || o_tx_data !== 8'h3C) $display("FAIL noack_next: got %h want 3c", o_tx_data); else pass_cnt++;
    wait_drain(200, ok);
    total_cnt++; if (!ok || o_err !== 1'b1) $display("FAIL noack_sticky: got err=%b want 1", o_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int b_st;
    bit ok;
    tx_hold = 40;
    push0(8'h77);
    wait_strobe(50, ok);
    repeat (5) @(negedge i_clk);
    total_cnt++; if (!ok || o_busy !== 1'b1 || o_grant !== 2'b01)
      $display("FAIL midrst_pre: got busy=%b grant=%b want 1/01", o_busy, o_grant);
    else pass_cnt++;
    i_rst_n = 1'b0;
    #1;
    total_cnt++; if (o_busy !== 1'b0 || o_grant !== 2'b00 || o_err !== 1'b0)
      $display("FAIL midrst_state: got busy=%b grant=%b err=%b want 0/00/0", o_busy, o_grant, o_err);
    else pass_cnt++;
    total_cnt++; if (o_tx_data !== 8'h00 || o_tx_data_valid !== 1'b0 || o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0)
      $display("FAIL midrst_outputs: got data=%h valid=%b r0=%b r1=%b want 00/0/0/0",
               o_tx_data, o_tx_data_valid, o_req0_ready, o_req1_ready);
    else pass_cnt++;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    b_st = st_n;
    repeat (20) @(negedge i_clk);
    total_cnt++; if (st_n !== b_st) $display("FAIL midrst_no_strobe: got %0d strobes want 0", st_n - b_st); else pass_cnt++;
    tx_hold = 4;
    push0(8'h78);
    wait_strobe(50, ok);
    total_cnt++; if (!ok || o_tx_data !== 8'h78) $display("FAIL midrst_resume: got %h want 78", o_tx_data); else pass_cnt++;
    wait_drain(200, ok);
  endtask

  task automatic test_busy_high();
    int b_r0;
    bit ok;
    force_busy = 1;
    b_r0 = rdy0_cnt;
    push0(8'h42);
    repeat (10) @(negedge i_clk);
    total_cnt++; if (rdy0_cnt !== b_r0 || o_busy !== 1'b0)
      $display("FAIL busyhigh_hold: got readies=%0d busy=%b want 0/0", rdy0_cnt - b_r0, o_busy);
    else pass_cnt++;
    force_busy = 0;
    wait_strobe(20, ok);
    total_cnt++; if (!ok || o_tx_data !== 8'h42 || rdy0_cnt - b_r0 !== 1)
      $display("FAIL busyhigh_release: got data=%h readies=%0d want 42/1", o_tx_data, rdy0_cnt - b_r0);
    else pass_cnt++;
    wait_drain(200, ok);
  endtask

  task automatic test_random();
    int ev_start, st_start, k0, k1, last_w, n_words;
    bit ok;
    logic [7:0] exp_q[$];
    logic [1:0] expg_q[$];
    do_reset();
    ev_start = ev_n; st_start = st_n; k0 = n0; k1 = n1;
    n_words = 40;
    for (int i = 0; i < n_words; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge i_clk);
      tx_hold = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 0) push0(8'($urandom_range(0, 255)));
      else push1(8'($urandom_range(0, 255)));
    end
    wait_drain(3000, ok);
    total_cnt++; if (!ok) $display("FAIL rand_drain: timeout got 0 want 1"); else pass_cnt++;
    total_cnt++; if (ev_n - ev_start !== n_words) $display("FAIL rand_accepts: got %0d want %0d", ev_n - ev_start, n_words); else pass_cnt++;
    // Reference: lone requester wins; on a tie the one not served last wins.
    last_w = -1;
    for (int e = ev_start; e < ev_n; e++) begin
      int w;
      if (ev_v0[e] && ev_v1[e]) w = (last_w == 0) ? 1 : 0;
      else w = ev_v1[e] ? 1 : 0;
      total_cnt++;
      if ((ev_r1[e] ? 1 : 0) !== w) $display("FAIL rand_winner[%0d]: got %0d want %0d", e - ev_start, ev_r1[e] ? 1 : 0, w);
      else pass_cnt++;
      last_w = w;
      if (w == 0) begin exp_q.push_back(words0[k0]); expg_q.push_back(2'b01); k0++; end
      else begin exp_q.push_back(words1[k1]); expg_q.push_back(2'b10); k1++; end
    end
    total_cnt++; if (st_n - st_start !== exp_q.size()) $display("FAIL rand_strobes: got %0d want %0d", st_n - st_start, exp_q.size()); else pass_cnt++;
    for (int s = st_start; s < st_n; s++) begin
      logic [7:0] ed;
      logic [1:0] eg;
      ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      eg = (expg_q.size() > 0) ? expg_q.pop_front() : 2'bxx;
      total_cnt++;
      if (st_data[s] !== ed || st_grant[s] !== eg)
        $display("FAIL rand_tx[%0d]: got %h/%b want %h/%b", s - st_start, st_data[s], st_grant[s], ed, eg);
      else pass_cnt++;
    end
  endtask

`ifdef SPI_ARB_LOCK_EN
  task automatic test_lock();
    int b_st;
    bit ok;
    logic [7:0] exp_d[4];
    exp_d[0] = 8'hB1; exp_d[1] = 8'hB2; exp_d[2] = 8'hB3; exp_d[3] = 8'hA1;
    do_reset();
    tx_hold = 4;
    lock1_mode = 1;
    b_st = st_n;
    push1(8'hB1); push1(8'hB2); push1(8'hB3);
    wait_strobe(50, ok);
    push0(8'hA1);
    wait_drain(500, ok);
    total_cnt++; if (!ok || st_n - b_st !== 4) $display("FAIL lock_count: got %0d want 4", st_n - b_st); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (st_data[b_st+i] !== exp_d[i]) $display("FAIL lock_order[%0d]: got %h want %h", i, st_data[b_st+i], exp_d[i]);
      else pass_cnt++;
    end
    lock1_mode = 0;
  endtask
`endif

  task automatic test_protocol();
    total_cnt++; if (viol_cnt !== 0) $display("FAIL protocol: got %0d violations want 0", viol_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_no_ack();
    test_reset_mid();
    test_busy_high();
    test_random();
`ifdef SPI_ARB_LOCK_EN
    test_lock();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
